// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with HI/LO registers and start/busy/done handshake
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d, done_q, done_d;
  logic               sa, sb;
  logic [WIDTH-1:0]   ma, mb, quo, rem;
  logic [WIDTH:0]     add_sum, trial;
  logic [2*WIDTH:0]   shl;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    sa      = ~op[0] & a[WIDTH-1];
    sb      = ~op[0] & b[WIDTH-1];
    ma      = sa ? -a : a;
    mb      = sb ? -b : b;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opd_q : '0};
    shl     = {acc_q, 1'b0};
    trial   = shl[2*WIDTH:WIDTH] - {1'b0, opd_q};
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (state_q == IDLE && start && !cancel) begin
      if (op <= 3'd3) begin
        // multiplier (mul) or dividend (div) sits in the low half and shifts out as the result forms
        acc_d   = {{WIDTH{1'b0}}, op[1] ? ma : mb};
        opd_d   = op[1] ? mb : ma;
        araw_d  = a;
        div_d   = op[1];
        neg_d   = sa ^ sb;
        rneg_d  = sa;
        bz_d    = b == '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = CALC;
      end else begin
        hi_d = op == 3'd4 ? a : hi_q;
        lo_d = op == 3'd5 ? a : lo_q;
      end
    end
    if (state_q == CALC) begin
      acc_d   = !div_q ? {add_sum, acc_q[WIDTH-1:1]}
              : trial[WIDTH] ? shl[2*WIDTH-1:0] : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? FIX : CALC;
    end
    if (state_q == FIX) begin
      hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] : bz_q ? araw_q : rem;
      lo_d    = !div_q ? prod[WIDTH-1:0] : bz_q ? '1 : quo;
      done_d  = 1'b1;
      state_d = IDLE;
    end
    if (cancel && state_q != IDLE) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32
module tb_muldiv_unit;
  logic        clk = 0, rst = 1, start = 0, cancel = 0;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          errors = 0, checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp;
  int          lat;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    logic signed [31:0] sx, sy, q, r;
    sx = x;
    sy = y;
    if (o == 3'd0) begin
      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      return p;
    end
    if (o == 3'd1) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 3'd3) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    q = sx / sy;
    r = sx % sy;
    return {r, q};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 0;
    if (o <= 3'd3) exp_q.push_back(model(o, x, y));
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b hi=%h lo=%h, need all 0", busy, done, hi, lo);
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept op=%0d got %b need 1", o, busy);
    end
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL latency op=%0d got %0d need 33", o, lat);
    end
    checks++;
    if ({hi, lo} !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h busy=%b need hi=%h lo=%h busy=0",
               o, x, y, hi, lo, busy, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_plan_values;
    test_op(3'd0, 32'hFFFFFFFF, 32'd2);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin
      errors++;
      $display("FAIL mult_const got %h%h need FFFFFFFFFFFFFFFE", hi, lo);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b need 0", done);
    end
    test_op(3'd1, 32'hFFFFFFFF, 32'd2);
    checks++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin
      errors++;
      $display("FAIL multu_const got %h%h need 00000001FFFFFFFE", hi, lo);
    end
    test_op(3'd2, 32'hFFFFFFF9, 32'd2);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_const got %h%h need FFFFFFFFFFFFFFFD", hi, lo);
    end
    test_op(3'd3, 32'd7, 32'd2);
    test_op(3'd3, 32'h12345678, 32'd0);
    checks++;
    if ({hi, lo} !== 64'h12345678_FFFFFFFF) begin
      errors++;
      $display("FAIL divu_by_zero got %h%h need 12345678FFFFFFFF", hi, lo);
    end
    test_op(3'd2, 32'hF0000000, 32'd0);
    test_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if ({hi, lo} !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_overflow got %h%h need 0000000080000000", hi, lo);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] y;
      y = (i % 3 == 0) ? $urandom_range(1, 20) : $urandom;
      if (i % 2 == 0) y = $urandom_range(0, 1) ? -y : y;
      test_op(3'($urandom_range(0, 3)), $urandom, y);
    end
  endtask

  task automatic test_mtx;
    @(negedge clk);
    start = 1; op = 3'd5; a = 32'hA5A5A5A5;
    @(posedge clk);
    #1 start = 0;
    checks++;
    if (lo !== 32'hA5A5A5A5 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo lo=%h busy=%b done=%b need A5A5A5A5/0/0", lo, busy, done);
    end
    @(negedge clk);
    start = 1; op = 3'd4; a = 32'h5A5A0001;
    @(posedge clk);
    #1 start = 0;
    checks++;
    if ({hi, lo} !== 64'h5A5A0001_A5A5A5A5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi hi=%h lo=%h busy=%b need 5A5A0001/A5A5A5A5/0", hi, lo, busy);
    end
    @(negedge clk);
    start = 1; op = 3'd6; a = 32'h0BADF00D; b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    checks++;
    if ({hi, lo} !== 64'h5A5A0001_A5A5A5A5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op hi=%h lo=%h busy=%b need unchanged/0", hi, lo, busy);
    end
  endtask

  task automatic test_ignored_start;
    int extra;
    issue(3'd0, 32'd1000, 32'hFFFFFFFD);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1; op = 3'd1; a = 32'hFFFF0000; b = 32'h00FF00FF;
    @(posedge clk);
    @(negedge clk);
    op = 3'd4;
    @(posedge clk);
    #1 start = 0;
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat < 0 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL ignored_start lat=%0d got hi=%h lo=%h need hi=%h lo=%h", lat, hi, lo, exp[63:32], exp[31:0]);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_start_extra busy/done cycles got %0d need 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    issue(3'd1, 32'd123456, 32'd654321);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat != 33 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL b2b_first lat=%0d got %h%h need 33 %h", lat, hi, lo, exp);
    end
    issue(3'd2, 32'hFFFFFF9C, 32'd7);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat != 33 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL b2b_second lat=%0d got %h%h need 33 %h", lat, hi, lo, exp);
    end
  endtask

  task automatic test_cancel;
    logic [63:0] prior;
    int seen;
    prior = {hi, lo};
    issue(3'd2, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk) cancel = 1;
    @(posedge clk);
    #1 cancel = 0;
    void'(exp_q.pop_front());
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy got %b need 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || {hi, lo} !== prior) begin
      errors++;
      $display("FAIL cancel_state done_pulses=%0d hi=%h lo=%h need 0 %h", seen, hi, lo, prior);
    end
    @(negedge clk);
    start = 1; op = 3'd5; a = 32'h11112222; cancel = 1;
    @(posedge clk);
    #1 start = 0; cancel = 0;
    checks++;
    if (lo !== prior[31:0] || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle_start lo=%h busy=%b need %h 0", lo, busy, prior[31:0]);
    end
  endtask

  task automatic test_async_reset;
    issue(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h need all 0", busy, done, hi, lo);
    end
    @(negedge clk) rst = 0;
    test_op(3'd0, 32'd3, 32'd5);
    checks++;
    if ({hi, lo} !== 64'd15) begin
      errors++;
      $display("FAIL after_reset_mult got %h%h need 000000000000000F", hi, lo);
    end
  endtask

  initial begin
    test_reset;
    test_plan_values;
    test_random;
    test_mtx;
    test_ignored_start;
    test_back_to_back;
    test_cancel;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
